dpi_wr_stager: RTL and testbench

DPI_WR_STAGER -- requirements
Module: dpi_wr_stager

---
 rtl/dpi_bus_pkg.sv | 23 ++
 rtl/dpi_wr_fifo.sv | 71 +++++++
 rtl/dpi_wr_stager.sv | 107 ++++++++++
 tb/tb_dpi_wr_stager.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_bus_pkg.sv
// dpi_bus_pkg
//   Shared definitions for the DPI write-stager slice.
//   - DEFAULT_AW / DEFAULT_DW : default address and data widths
//   - WR_DONE_MAX             : ceiling of the completed-write counter
//   - stager_state_e          : write-stager FSM states (IDLE, REQ, GAP)
//   - sat_inc16()             : saturating 16-bit increment
package dpi_bus_pkg;

    localparam int          DEFAULT_AW  = 32;
    localparam int          DEFAULT_DW  = 32;
    localparam logic [15:0] WR_DONE_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } stager_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == WR_DONE_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dpi_wr_fifo.sv
// dpi_wr_fifo
//   Write-queue storage for the stager: DEPTH entries of W bits.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     push, wdata    enqueue request and entry (ignored when full)
//     pop            dequeue request (ignored when empty)
//     rdata          head entry (valid while not empty)
//     full, empty    occupancy flags
//     level          registered occupancy, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally.
module dpi_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // simultaneous push and pop leaves the occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/dpi_wr_stager.sv
// dpi_wr_stager
//   Queues upstream writes and presents them one at a time to the downstream
//   bus with a req/ack handshake, leaving one idle cycle between writes.
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     in_valid/in_ready           upstream write handshake
//     in_addr, in_data            upstream write payload
//     out_req/out_ack             downstream write handshake
//     out_addr, out_data          presented write (meaningful while out_req=1)
//     level                       entries currently queued
//     wr_done                     saturating count of completed writes
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | queue empty, nothing presented
//   REQ   | head write presented (out_req=1), waiting for out_ack
//   GAP   | one-cycle spacer after a completed write, out_req=0
module dpi_wr_stager
    import dpi_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [DW-1:0]          in_data,
    output logic                   out_req,
    input  logic                   out_ack,
    output logic [AW-1:0]          out_addr,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            wr_done
);

    stager_state_e     state;
    logic [AW+DW-1:0]  head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // in_ready follows the registered occupancy only; a pop in the same
    // cycle does not open a slot for a full queue.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // out_req is high exactly while in REQ, so an ack in IDLE/GAP is ignored.
    assign pop      = out_req && out_ack;

    assign {out_addr, out_data} = head;

    dpi_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_addr, in_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            out_req <= 1'b0;
            wr_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= REQ;
                        out_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (out_ack) begin
                        state   <= GAP;
                        out_req <= 1'b0;
                        wr_done <= sat_inc16(wr_done);
                    end
                end
                GAP: begin
                    if (!empty) begin
                        state   <= REQ;
                        out_req <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        out_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    out_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpi_wr_stager.sv
module tb_dpi_wr_stager;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_req;
    logic          out_ack = 1'b0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [2:0]    level;
    logic [15:0]   wr_done;

    int n_tests = 0;
    int n_fail  = 0;

    dpi_wr_stager #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_addr (out_addr),
        .out_data (out_data),
        .level    (level),
        .wr_done  (wr_done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending writes, whether a write is being
    // presented, and the number of completed writes since reset.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t         m_q[$];
    bit          m_req;
    int          m_pops;
    int          m_lvl;
    bit          m_push;
    bit          m_pop;
    logic [15:0] m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_req  = 1'b0;
            m_pops = 0;
        end else begin
            m_lvl  = m_q.size();
            m_push = in_valid && (m_lvl != DEPTH);
            m_pop  = m_req && out_ack;
            // a presented write stays up until acked; after an ack there is
            // one dead cycle; otherwise a write is presented whenever one is queued
            if (m_req) m_req = !m_pop;
            else       m_req = (m_lvl != 0);
            if (m_pop) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (m_push) m_q.push_back('{in_addr, in_data});
        end
    end

    assign m_done = (m_pops > 65535) ? 16'hFFFF : 16'(m_pops);

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ack = 1'b0;
        #3;
        n_tests++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL reset_out_req: got %0b exp 0", out_req); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d exp 0", level); end
        n_tests++; if (wr_done !== 16'd0) begin n_fail++; $display("FAIL reset_wr_done: got %0h exp 0", wr_done); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
        @(posedge clk); #1;
        n_tests++; if (out_req !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL reset_hold: got req=%0b level=%0d exp 0/0", out_req, level); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h10; in_data = 32'hA5; out_ack = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd1 || out_req !== 1'b0) begin n_fail++; $display("FAIL single_accept: got level=%0d req=%0b exp 1/0", level, out_req); end
        @(negedge clk);
        n_tests++; if (out_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %0b exp 1", out_req); end
        n_tests++; if (out_addr !== 32'h10 || out_data !== 32'hA5) begin n_fail++; $display("FAIL single_payload: got %0h/%0h exp 10/a5", out_addr, out_data); end
        @(negedge clk);
        out_ack = 1'b0;
        n_tests++; if (out_req !== 1'b0 || wr_done !== 16'd1 || level !== 3'd0) begin n_fail++; $display("FAIL single_done: got req=%0b done=%0d level=%0d exp 0/1/0", out_req, wr_done, level); end
    endtask

    task automatic test_fill();
        int nxt;
        out_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %0b exp 1", i, in_ready); end
            in_valid = 1'b1; in_addr = 32'h100 + i; in_data = 32'h200 + i;
        end
        @(negedge clk);
        in_addr = 32'h104; in_data = 32'h204;
        n_tests++; if (level !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got level=%0d ready=%0b exp 4/0", level, in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (level !== 3'd4 || in_ready !== 1'b0 || out_req !== 1'b1 || out_addr !== 32'h100) begin
                n_fail++; $display("FAIL fill_hold_%0d: got level=%0d ready=%0b req=%0b addr=%0h exp 4/0/1/100", i, level, in_ready, out_req, out_addr);
            end
        end
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        n_tests++; if (level !== 3'd3 || in_ready !== 1'b1 || out_req !== 1'b0) begin n_fail++; $display("FAIL fill_first_pop: got level=%0d ready=%0b req=%0b exp 3/1/0", level, in_ready, out_req); end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd4 || out_req !== 1'b1 || out_addr !== 32'h101 || out_data !== 32'h201) begin
            n_fail++; $display("FAIL fill_fifth_in: got level=%0d req=%0b addr=%0h data=%0h exp 4/1/101/201", level, out_req, out_addr, out_data);
        end
        out_ack = 1'b1;
        nxt = 2;
        for (int cyc = 0; cyc < 30 && !(nxt == 5 && level == 0); cyc++) begin
            @(negedge clk);
            if (out_req === 1'b1) begin
                n_tests++; if (out_addr !== 32'h100 + nxt || out_data !== 32'h200 + nxt) begin
                    n_fail++; $display("FAIL fill_order_%0d: got %0h/%0h exp %0h/%0h", nxt, out_addr, out_data, 32'h100 + nxt, 32'h200 + nxt);
                end
                nxt++;
            end
        end
        out_ack = 1'b0;
        n_tests++; if (nxt !== 5 || level !== 3'd0) begin n_fail++; $display("FAIL fill_drain: got presented=%0d level=%0d exp 5/0", nxt, level); end
        n_tests++; if (wr_done !== 16'd6) begin n_fail++; $display("FAIL fill_wr_done: got %0d exp 6", wr_done); end
    endtask

    task automatic test_order();
        logic [31:0] ea[3];
        logic [31:0] ed[3];
        int k;
        int dly;
        bit acked;
        bit in_gap;
        int start;
        ea[0] = 32'h1; ea[1] = 32'h2; ea[2] = 32'h3;
        ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h33;
        start = m_pops;
        out_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_addr = ea[i]; in_data = ed[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        k = 0; acked = 1'b0; in_gap = 1'b0;
        dly = $urandom_range(5);
        for (int cyc = 0; cyc < 200 && k < 3; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (acked) begin
                out_ack = 1'b0;
                n_tests++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL order_gap_%0d: got req=%0b exp 0", k, out_req); end
                acked = 1'b0;
                k++;
                dly = $urandom_range(5);
                in_gap = (k < 3);
            end else begin
                if (in_gap) begin
                    n_tests++; if (out_req !== 1'b1) begin n_fail++; $display("FAIL order_gap_len_%0d: got req=%0b exp 1", k, out_req); end
                    in_gap = 1'b0;
                end
                if (out_req === 1'b1) begin
                    n_tests++; if (out_addr !== ea[k] || out_data !== ed[k]) begin
                        n_fail++; $display("FAIL order_item_%0d: got %0h/%0h exp %0h/%0h", k, out_addr, out_data, ea[k], ed[k]);
                    end
                    if (dly == 0) begin out_ack = 1'b1; acked = 1'b1; end
                    else dly--;
                end
            end
        end
        out_ack = 1'b0;
        n_tests++; if (k !== 3) begin n_fail++; $display("FAIL order_timeout: got %0d writes exp 3", k); end
        n_tests++; if (int'(wr_done) !== start + 3 || level !== 3'd0) begin n_fail++; $display("FAIL order_done: got done=%0d level=%0d exp %0d/0", wr_done, level, start + 3); end
    endtask

    task automatic test_ack_ignored();
        int start;
        start = m_pops;
        @(negedge clk);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        n_tests++; if (level !== 3'd0 || int'(wr_done) !== start || out_req !== 1'b0) begin
            n_fail++; $display("FAIL ack_idle: got level=%0d done=%0d req=%0b exp 0/%0d/0", level, wr_done, out_req, start);
        end
        @(negedge clk); in_valid = 1'b1; in_addr = 32'hA0; in_data = 32'hB0;
        @(negedge clk); in_addr = 32'hA1; in_data = 32'hB1;
        @(negedge clk); in_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && out_req !== 1'b1; cyc++) @(negedge clk);
        n_tests++; if (out_req !== 1'b1 || out_addr !== 32'hA0) begin n_fail++; $display("FAIL ack_first_req: got req=%0b addr=%0h exp 1/a0", out_req, out_addr); end
        out_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (level !== 3'd1 || int'(wr_done) !== start + 1 || out_req !== 1'b0) begin
            n_fail++; $display("FAIL ack_pop: got level=%0d done=%0d req=%0b exp 1/%0d/0", level, wr_done, out_req, start + 1);
        end
        @(negedge clk);
        out_ack = 1'b0;
        n_tests++; if (level !== 3'd1 || int'(wr_done) !== start + 1 || out_req !== 1'b1 || out_addr !== 32'hA1) begin
            n_fail++; $display("FAIL ack_gap: got level=%0d done=%0d req=%0b addr=%0h exp 1/%0d/1/a1", level, wr_done, out_req, out_addr, start + 1);
        end
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        n_tests++; if (level !== 3'd0 || int'(wr_done) !== start + 2) begin n_fail++; $display("FAIL ack_last: got level=%0d done=%0d exp 0/%0d", level, wr_done, start + 2); end
    endtask

    task automatic test_random();
        int ack_pct;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            n_tests++; if (int'(level) !== m_q.size()) begin n_fail++; $display("FAIL rand_level@%0d: got %0d exp %0d", cyc, level, m_q.size()); end
            n_tests++; if (in_ready !== (m_q.size() != DEPTH)) begin n_fail++; $display("FAIL rand_ready@%0d: got %0b exp %0b", cyc, in_ready, m_q.size() != DEPTH); end
            n_tests++; if (out_req !== m_req) begin n_fail++; $display("FAIL rand_req@%0d: got %0b exp %0b", cyc, out_req, m_req); end
            n_tests++; if (wr_done !== m_done) begin n_fail++; $display("FAIL rand_done@%0d: got %0d exp %0d", cyc, wr_done, m_done); end
            if (m_req && m_q.size() > 0) begin
                n_tests++; if (out_addr !== m_q[0].a || out_data !== m_q[0].d) begin
                    n_fail++; $display("FAIL rand_payload@%0d: got %0h/%0h exp %0h/%0h", cyc, out_addr, out_data, m_q[0].a, m_q[0].d);
                end
            end
            ack_pct  = (cyc < 750) ? 30 : 80;
            in_valid = ($urandom_range(99) < 60);
            in_addr  = $urandom;
            in_data  = $urandom;
            out_ack  = ($urandom_range(99) < ack_pct);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b0; out_ack = 1'b1;
        for (int cyc = 0; cyc < 40 && !(m_q.size() == 0 && !m_req); cyc++) @(negedge clk);
        out_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 32'h300 + i; in_data = 32'h400 + i;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd3 || out_req !== 1'b1 || wr_done !== m_done) begin
            n_fail++; $display("FAIL rmid_pre: got level=%0d req=%0b done=%0d exp 3/1/%0d", level, out_req, wr_done, m_done);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (out_req !== 1'b0 || level !== 3'd0 || wr_done !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_async: got req=%0b level=%0d done=%0d ready=%0b exp 0/0/0/1", out_req, level, wr_done, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_addr = 32'h40; in_data = 32'h77;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL rmid_first_accept: got level=%0d exp 1", level); end
        @(negedge clk);
        n_tests++; if (out_req !== 1'b1 || out_addr !== 32'h40 || out_data !== 32'h77) begin
            n_fail++; $display("FAIL rmid_present: got req=%0b %0h/%0h exp 1/40/77", out_req, out_addr, out_data);
        end
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        n_tests++; if (wr_done !== 16'd1 || level !== 3'd0) begin n_fail++; $display("FAIL rmid_done: got done=%0d level=%0d exp 1/0", wr_done, level); end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_done;
        @(negedge clk);
        force dut.wr_done = 16'hFFFE;
        #1 release dut.wr_done;
        n_tests++; if (wr_done !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %0h exp fffe", wr_done); end
        exp_done = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_addr = 32'h500 + i; in_data = 32'h600 + i; out_ack = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            if (exp_done != 16'hFFFF) exp_done = exp_done + 16'd1;
            n_tests++; if (wr_done !== exp_done) begin n_fail++; $display("FAIL sat_write_%0d: got %0h exp %0h", i, wr_done, exp_done); end
        end
        out_ack = 1'b0;
        n_tests++; if (wr_done !== 16'hFFFF || level !== 3'd0) begin n_fail++; $display("FAIL sat_final: got done=%0h level=%0d exp ffff/0", wr_done, level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_order();
        test_ack_ignored();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
